// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Constants shared by the pipeline stages. These are the
//               datapath width, the instruction width, the reset PC and the
//               bubble encoding that decode recognises as "no instruction".
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Address/data width of the core.
  localparam int XLEN = 32;

  // Instruction word width. This is also the IF/ID instr field width.
  localparam int ILEN = 32;

  // PC loaded on reset.
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // Bubble written into IF/ID. This is addi x0,x0,0.
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // IF/ID field widths: pc, pc4, instr, valid.
  localparam int IF_ID_PC_W    = XLEN;
  localparam int IF_ID_PC4_W   = XLEN;
  localparam int IF_ID_INSTR_W = ILEN;
  localparam int IF_ID_VALID_W = 1;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with bubble, hold and load controls.
//               If both bubble and hold are asserted, the bubble wins.
//               A bubble loads NOP_INSTR with valid=0. The bubble still
//               records the pc/pc4 that were presented.
// Ports       : clk, rst        - clock, async active-high reset
//               i_hold          - keep current contents
//               i_bubble        - load a bubble
//               i_pc/i_pc4      - PC and PC+4 of the incoming word
//               i_instr         - incoming instruction word
//               o_pc/o_pc4/o_instr/o_valid - registered IF/ID contents
//               o_load_valid    - a real instruction is loaded this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
  parameter int                          XLEN      = pipe_pkg::XLEN,
  parameter logic [pipe_pkg::ILEN-1:0]   NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_hold,
  input  logic                      i_bubble,
  input  logic [XLEN-1:0]           i_pc,
  input  logic [XLEN-1:0]           i_pc4,
  input  logic [pipe_pkg::ILEN-1:0] i_instr,
  output logic [XLEN-1:0]           o_pc,
  output logic [XLEN-1:0]           o_pc4,
  output logic [pipe_pkg::ILEN-1:0] o_instr,
  output logic                      o_valid,
  output logic                      o_load_valid
);

  logic [XLEN-1:0]           r_pc;
  logic [XLEN-1:0]           r_pc4;
  logic [pipe_pkg::ILEN-1:0] r_instr;
  logic                      r_valid;

  assign o_load_valid = !i_bubble && !i_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_pc4   <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_bubble) begin
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. It holds the PC and drives the
//               instruction-memory address. It registers the fetched word
//               into IF/ID and counts the valid fetches.
//               A redirect has priority over a stall for the next PC.
//               A redirect or a flush turns the IF/ID load into a bubble.
// Ports       : clk, rst            - clock, async active-high reset
//               stall_i             - hold PC and IF/ID
//               flush_i             - bubble into IF/ID, PC unaffected
//               redirect_i          - taken branch/jump from EX
//               redirect_pc_i       - redirect target (low 2 bits ignored)
//               imem_addr_o         - instruction-memory address (= PC)
//               imem_rdata_i        - combinational read of imem_addr_o
//               if_id_pc_o/_pc4_o   - PC / PC+4 of the IF/ID instruction
//               if_id_instr_o       - IF/ID instruction
//               if_id_valid_o       - IF/ID holds a real instruction
//               fetch_count_o       - valid instructions loaded into IF/ID
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int                        XLEN      = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0]           RESET_PC  = XLEN'(pipe_pkg::RESET_PC),
  parameter logic [pipe_pkg::ILEN-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      redirect_i,
  input  logic [XLEN-1:0]           redirect_pc_i,
  output logic [XLEN-1:0]           imem_addr_o,
  input  logic [pipe_pkg::ILEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0]           if_id_pc_o,
  output logic [XLEN-1:0]           if_id_pc4_o,
  output logic [pipe_pkg::ILEN-1:0] if_id_instr_o,
  output logic                      if_id_valid_o,
  output logic [31:0]               fetch_count_o
);

  import pipe_pkg::*;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [31:0]     r_fetch_count;
  logic            w_load_valid;

  // The addition wraps naturally: 0xFFFF_FFFC + 4 = 0.
  assign w_pc4 = r_pc + XLEN'(4);

  // Instructions are word aligned, so the low target bits are dropped.
  assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

  always_comb begin
    w_pc_next = w_pc4;
    if (redirect_i) begin
      w_pc_next = w_redirect_pc;
    end else if (stall_i) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign imem_addr_o = r_pc;

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk          (clk),
    .rst          (rst),
    .i_hold       (stall_i),
    .i_bubble     (redirect_i | flush_i),
    .i_pc         (r_pc),
    .i_pc4        (w_pc4),
    .i_instr      (imem_rdata_i),
    .o_pc         (if_id_pc_o),
    .o_pc4        (if_id_pc4_o),
    .o_instr      (if_id_instr_o),
    .o_valid      (if_id_valid_o),
    .o_load_valid (w_load_valid)
  );

  // The counter advances only when IF/ID takes a real instruction.
  // It wraps 0xFFFF_FFFF -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_load_valid) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count_o = r_fetch_count;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage. The memory
//               model returns addr ^ 0x0010_0093. Each fetched word can
//               then be traced back to its address, and address 0 returns
//               0x0010_0093.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_nop  = 32'h0000_0013;
  localparam logic [31:0] c_salt = 32'h0010_0093;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic [31:0] fetch_count_o;

  int n_cmp;
  int n_bad;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_valid_o (if_id_valid_o),
    .fetch_count_o (fetch_count_o)
  );

  assign imem_rdata_i = imem_addr_o ^ c_salt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the PC and the full IF/ID contents in one call.
  task automatic check_state(input string tag, input logic [31:0] pc,
                             input logic [31:0] ipc, input logic [31:0] instr,
                             input logic valid, input logic [31:0] cnt);
    check_eq({tag, ".addr"},  imem_addr_o, pc);
    check_eq({tag, ".pc"},    if_id_pc_o, ipc);
    check_eq({tag, ".pc4"},   if_id_pc4_o, ipc + 32'd4);
    check_eq({tag, ".instr"}, if_id_instr_o, instr);
    check_eq({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, valid});
    check_eq({tag, ".count"}, fetch_count_o, cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'd0;

    #12;
    check_eq("rst.addr",  imem_addr_o, 32'h0);
    check_eq("rst.pc",    if_id_pc_o, 32'h0);
    check_eq("rst.pc4",   if_id_pc4_o, 32'h0);
    check_eq("rst.instr", if_id_instr_o, c_nop);
    check_eq("rst.valid", {31'd0, if_id_valid_o}, 32'd0);
    check_eq("rst.count", fetch_count_o, 32'd0);

    @(negedge clk);
    rst = 1'b0;

    // Free run from PC 0.
    tick(); check_state("run1", 32'h4, 32'h0, 32'h0010_0093, 1'b1, 32'd1);
    tick(); check_state("run2", 32'h8, 32'h4, 32'h0010_0097, 1'b1, 32'd2);

    // Three-cycle stall at PC 8.
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); check_state("stall", 32'h8, 32'h4, 32'h0010_0097, 1'b1, 32'd2);
    end
    stall_i = 1'b0;
    tick(); check_state("resume1", 32'hC,  32'h8, 32'h0010_009B, 1'b1, 32'd3);
    tick(); check_state("resume2", 32'h10, 32'hC, 32'h0010_009F, 1'b1, 32'd4);

    // Redirect to 0x103, which aligns to 0x100.
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    tick(); check_state("redir", 32'h100, 32'h10, c_nop, 1'b0, 32'd4);
    redirect_i = 1'b0;
    tick(); check_state("redir_tgt", 32'h104, 32'h100, 32'h0010_0193, 1'b1, 32'd5);

    // Redirect, stall and flush together: redirect wins.
    redirect_i = 1'b1;
    stall_i = 1'b1;
    flush_i = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    tick(); check_state("all3", 32'h200, 32'h104, c_nop, 1'b0, 32'd5);
    redirect_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    tick(); check_state("all3_tgt", 32'h204, 32'h200, 32'h0010_0293, 1'b1, 32'd6);

    // Stall with flush: PC held, bubble in IF/ID.
    stall_i = 1'b1;
    flush_i = 1'b1;
    tick(); check_state("stflush", 32'h204, 32'h204, c_nop, 1'b0, 32'd6);
    stall_i = 1'b0;
    flush_i = 1'b0;
    tick(); check_state("stflush_after", 32'h208, 32'h204, 32'h0010_0297, 1'b1, 32'd7);

    // Flush alone: PC advances, bubble in IF/ID.
    flush_i = 1'b1;
    tick(); check_state("flush", 32'h20C, 32'h208, c_nop, 1'b0, 32'd7);
    flush_i = 1'b0;

    // Redirect near the top of the address space, then wrap to 0.
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    tick(); check_state("wrap_redir", 32'hFFFF_FFFC, 32'h20C, c_nop, 1'b0, 32'd7);
    redirect_i = 1'b0;
    tick();
    check_eq("wrap.addr",  imem_addr_o, 32'h0);
    check_eq("wrap.pc",    if_id_pc_o, 32'hFFFF_FFFC);
    check_eq("wrap.pc4",   if_id_pc4_o, 32'h0);
    check_eq("wrap.instr", if_id_instr_o, 32'hFFEF_FF6F);
    check_eq("wrap.count", fetch_count_o, 32'd8);
    tick(); check_state("wrap_next", 32'h4, 32'h0, 32'h0010_0093, 1'b1, 32'd9);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst.addr",  imem_addr_o, 32'h0);
    check_eq("arst.valid", {31'd0, if_id_valid_o}, 32'd0);
    check_eq("arst.instr", if_id_instr_o, c_nop);
    check_eq("arst.pc",    if_id_pc_o, 32'h0);
    check_eq("arst.count", fetch_count_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(); check_state("post_rst", 32'h4, 32'h0, 32'h0010_0093, 1'b1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
